forwarding_source: RTL and testbench
====================================

# forwarding_source

Producer side of the register-forwarding network. Tracks the destination register of every in-flight instruction through the EX, MEM and WB slots, captures results as they become available, and publishes one `stage_register_data_t` per slot for the hazard unit to consume. It also owns the multi-cycle waits for the divider and for data memory, and performs the general-purpose-register write at WB.

## Interface
Parameters:
- `DIV_MAX_CYCLES`, default 64: maximum cycles a DIV may wait in EX before the timeout is forced.

Ports. Clock is `clock`; reset is `reset`, synchronous and active-high.
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `issueValid` in 1: an instruction enters EX on the next advance. When 0, a bubble enters.
- `issueRegisterId` in 5: destination register (`register_id_t`).
- `issueKind` in 2: 0 NONE (no write), 1 ALU, 2 LOAD, 3 DIV.
- `exResult` in 32: ALU result of the instruction currently in EX.
- `memDataValid` in 1: level; `memReadData` is valid this cycle.
- `memReadData` in 32: load data for the instruction in MEM.
- `divStart` out 1: one-cycle pulse, issued once per DIV.
- `divDone` in 1: one-cycle pulse; `divResult` is valid.
- `divResult` in 32: divider quotient.
- `holdRequest` out 1: combinational. When 1, all slots freeze and upstream must not issue.
- `dataToHazardUnit` out 3 x `stage_register_data_t`: index 0 EX, 1 MEM, 2 WB.
- `regWrite` out 1: GPR write enable.
- `regWriteId` out 5: GPR write register.
- `regWriteData` out 32: GPR write data.
- `divTimeout` out 1: sticky error flag, cleared only by reset.

## Operation
- **Slot state.** Each slot holds `valid`, `registerId`, `kind`, `ready`, `data`. A slot that is invalid or of kind NONE publishes `{ZERO, 1, 0}`.
- **Advance.** Advance happens when `holdRequest == 0`: WB <- MEM, MEM <- EX, EX <- issue (or a bubble).
- **ALU.**
  - In EX it publishes `ready = 1` with `data = exResult`, passed through combinationally.
  - On advance, `exResult` is latched into the MEM slot.
- **LOAD.**
  - In EX it publishes `ready = 0`.
  - In MEM it publishes `ready = 0` until the first cycle `memDataValid == 1`. In that cycle `memReadData` is captured, and from the next cycle onward the slot publishes `ready = 1` with the captured data.
- **DIV.**
  - `divStart` pulses in the first cycle a DIV occupies EX.
  - `divDone` is ignored in the cycle `divStart` is high, and whenever EX does not hold a waiting DIV.
  - On `divDone`, `divResult` is captured and the slot becomes ready.
  - A wait counter increments each cycle the DIV waits. When it reaches `DIV_MAX_CYCLES`, the slot captures 0, sets ready, and sets `divTimeout`.
- **Hold condition.** `holdRequest = (EX is DIV && !ready) || (MEM is LOAD && !ready)`.
  - A capture in the current cycle does not clear the hold until the next cycle.
  - Both waits may be pending at once; each resolves independently, and the advance occurs only when neither is pending.
- **Writeback.** `regWrite = WB valid && kind != NONE && registerId != ZERO && !holdRequest`. Each instruction is written exactly once.
- **Register ZERO.** An instruction with destination ZERO occupies its slot but publishes `{ZERO, 1, 0}`.

## Timing
- **Reset values.** All slots invalid; all three entries `{ZERO, 1, 0}`; `holdRequest`, `divStart`, `regWrite` and `divTimeout` are 0; `regWriteId` is ZERO; `regWriteData` is 0; the wait counter is 0.
- **Reset mid-operation.** Reset mid-wait discards all slots, and no pending write is performed.
- **Registered vs combinational outputs.** Slot contents are registered at posedge. Outputs are combinational from slot state, plus `exResult` for an ALU instruction in EX. This keeps them stable for the hazard unit's negedge sample.
- **Latency.**
  - Issue to WB write: 3 cycles with no hold.
  - LOAD: data is forwarded one cycle after the `memDataValid` capture.
  - DIV: data is forwarded one cycle after `divDone`.
- **Timeout timing.** A timeout with `DIV_MAX_CYCLES = N` asserts `divTimeout` N cycles after `divStart`.

## Test plan
- **Back-to-back ALU.** Issue ALU r5 (`exResult = 0x11`), then ALU r6 (`exResult = 0x22`). Required:
  - Entry0 is `{r5, 1, 0x11}`.
  - Next cycle, entry1 is `{r5, 1, 0x11}` and entry0 is `{r6, 1, 0x22}`.
  - At cycle 3, `regWrite` r5 = 0x11.
- **LOAD with memory wait.** Issue LOAD r7; keep `memDataValid = 0` for 2 cycles in MEM, then 1 with `memReadData = 0xABCD`. Required:
  - `holdRequest = 1` for 3 cycles with entry1 `{r7, 0, x}`.
  - Then `{r7, 1, 0xABCD}`, and the slots advance.
  - A single `regWrite` of r7.
- **DIV.** Issue DIV r3; pulse `divDone` 4 cycles after `divStart` with `divResult = 9`. Required:
  - `divStart` is exactly one pulse.
  - Entry0 `{r3, 0}` while waiting, then `{r3, 1, 9}`.
  - Hold released the following cycle.
- **Simultaneous waits.** DIV in EX and LOAD in MEM; `divDone` arrives 2 cycles before `memDataValid`. Required: no advance until both are captured, and each result is published exactly once.
- **Timeout.** `DIV_MAX_CYCLES = 4`; `divDone` never arrives. Required:
  - `divTimeout = 1` after 4 cycles.
  - Entry0 `{r3, 1, 0}`.
  - Pipeline resumes.
- **ZERO, bubbles and reset.** Sequence: issue to r0, then a NONE, then a bubble, then assert reset mid-DIV wait. Required:
  - Every entry for these is `{ZERO, 1, 0}`, and there is no `regWrite`.
  - After reset, all outputs return to their reset values.

Source files
------------

// File: rtl/forwarding_source.sv
// Producer side of the register-forwarding network: tracks EX/MEM/WB destinations,
// captures ALU, load and divide results, owns the divider/memory waits and the GPR write.
package forwarding_source_pkg;
  localparam int unsigned REG_ID_W  = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned KIND_W    = 2;
  localparam int unsigned NUM_SLOTS = 3;

  typedef logic [REG_ID_W-1:0] register_id_t;

  localparam logic [KIND_W-1:0] KIND_NONE = 2'd0;
  localparam logic [KIND_W-1:0] KIND_ALU  = 2'd1;
  localparam logic [KIND_W-1:0] KIND_LOAD = 2'd2;
  localparam logic [KIND_W-1:0] KIND_DIV  = 2'd3;

  typedef struct packed {
    register_id_t      registerId;
    logic              ready;
    logic [DATA_W-1:0] data;
  } stage_register_data_t;

  typedef struct packed {
    logic              valid;
    register_id_t      registerId;
    logic [KIND_W-1:0] kind;
    logic              ready;
    logic [DATA_W-1:0] data;
  } slot_t;

  localparam stage_register_data_t ZERO_ENTRY = '{registerId: '0, ready: 1'b1, data: '0};
endpackage

module forwarding_source
  import forwarding_source_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYCLES = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 issueValid,
  input  register_id_t                         issueRegisterId,
  input  logic [KIND_W-1:0]                    issueKind,
  input  logic [DATA_W-1:0]                    exResult,
  input  logic                                 memDataValid,
  input  logic [DATA_W-1:0]                    memReadData,
  output logic                                 divStart,
  input  logic                                 divDone,
  input  logic [DATA_W-1:0]                    divResult,
  output logic                                 holdRequest,
  output stage_register_data_t [NUM_SLOTS-1:0] dataToHazardUnit,
  output logic                                 regWrite,
  output register_id_t                         regWriteId,
  output logic [DATA_W-1:0]                    regWriteData,
  output logic                                 divTimeout
);

  localparam int unsigned CNT_W = $clog2(DIV_MAX_CYCLES + 1);

  slot_t              r_ex;
  slot_t              r_mem;
  slot_t              r_wb;
  logic               r_div_started;
  logic [CNT_W-1:0]   r_div_cnt;
  logic               r_div_timeout;

  logic               w_ex_div_wait;
  logic               w_mem_load_wait;
  logic               w_div_accept;
  logic               w_div_expire;
  logic [CNT_W-1:0]   w_div_cnt_next;
  stage_register_data_t w_ex_entry;

  // A slot forwards only when it will really write a non-zero register.
  function automatic logic f_publishes(input slot_t s);
    return s.valid && (s.kind != KIND_NONE) && (s.registerId != '0);
  endfunction

  function automatic stage_register_data_t f_publish(input slot_t s);
    stage_register_data_t e;
    e = ZERO_ENTRY;
    if (f_publishes(s)) begin
      e.registerId = s.registerId;
      e.ready      = s.ready;
      e.data       = s.data;
    end
    return e;
  endfunction

  assign w_ex_div_wait   = r_ex.valid && (r_ex.kind == KIND_DIV) && !r_ex.ready;
  assign w_mem_load_wait = r_mem.valid && (r_mem.kind == KIND_LOAD) && !r_mem.ready;
  assign holdRequest     = w_ex_div_wait || w_mem_load_wait;

  // divDone is only honoured once the start pulse has gone out.
  assign divStart       = w_ex_div_wait && !r_div_started;
  assign w_div_accept   = w_ex_div_wait && r_div_started && divDone;
  assign w_div_cnt_next = CNT_W'(r_div_cnt + 1'b1);
  assign w_div_expire   = w_ex_div_wait && !w_div_accept &&
                          (w_div_cnt_next == CNT_W'(DIV_MAX_CYCLES));

  // ALU results in EX bypass the slot register.
  always_comb begin
    w_ex_entry = f_publish(r_ex);
    if (f_publishes(r_ex) && (r_ex.kind == KIND_ALU)) begin
      w_ex_entry.ready = 1'b1;
      w_ex_entry.data  = exResult;
    end
  end

  assign dataToHazardUnit[0] = w_ex_entry;
  assign dataToHazardUnit[1] = f_publish(r_mem);
  assign dataToHazardUnit[2] = f_publish(r_wb);

  assign regWrite     = f_publishes(r_wb) && !holdRequest;
  assign regWriteId   = regWrite ? r_wb.registerId : '0;
  assign regWriteData = regWrite ? r_wb.data : '0;
  assign divTimeout   = r_div_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb          <= '0;
      r_div_started <= 1'b0;
      r_div_cnt     <= '0;
      r_div_timeout <= 1'b0;
    end else begin
      if (w_div_expire) begin
        r_div_timeout <= 1'b1;
      end
      if (!holdRequest) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        if (r_ex.kind == KIND_ALU) begin
          r_mem.ready <= 1'b1;
          r_mem.data  <= exResult;
        end
        if (issueValid) begin
          r_ex <= '{valid: 1'b1, registerId: issueRegisterId, kind: issueKind,
                    ready: 1'b0, data: '0};
        end else begin
          r_ex <= '0;
        end
        r_div_started <= 1'b0;
        r_div_cnt     <= '0;
      end else begin
        if (divStart) begin
          r_div_started <= 1'b1;
        end
        if (w_ex_div_wait) begin
          r_div_cnt <= w_div_cnt_next;
        end
        if (w_div_accept) begin
          r_ex.ready <= 1'b1;
          r_ex.data  <= divResult;
        end else if (w_div_expire) begin
          r_ex.ready <= 1'b1;
          r_ex.data  <= '0;
        end
        if (w_mem_load_wait && memDataValid) begin
          r_mem.ready <= 1'b1;
          r_mem.data  <= memReadData;
        end
      end
    end
  end

endmodule

// File: tb/tb_forwarding_source.sv
// Directed bench for forwarding_source: ALU, load wait, divide, overlapping waits,
// divide timeout, register-zero/bubble handling and reset.
module tb_forwarding_source;
  import forwarding_source_pkg::*;

  logic                                 clock;
  logic                                 reset;
  logic                                 issueValid;
  register_id_t                         issueRegisterId;
  logic [1:0]                           issueKind;
  logic [31:0]                          exResult;
  logic                                 memDataValid;
  logic [31:0]                          memReadData;
  logic                                 divDone;
  logic [31:0]                          divResult;

  logic                                 div_start, hold, reg_write, div_timeout;
  register_id_t                         reg_write_id;
  logic [31:0]                          reg_write_data;
  stage_register_data_t [2:0]           hz;

  logic                                 to_div_start, to_hold, to_reg_write, to_div_timeout;
  register_id_t                         to_reg_write_id;
  logic [31:0]                          to_reg_write_data;
  stage_register_data_t [2:0]           to_hz;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt [32] = '{default: 0};
  int ds_cnt = 0;

  forwarding_source u_dut (
    .clock(clock), .reset(reset), .issueValid(issueValid), .issueRegisterId(issueRegisterId),
    .issueKind(issueKind), .exResult(exResult), .memDataValid(memDataValid),
    .memReadData(memReadData), .divStart(div_start), .divDone(divDone), .divResult(divResult),
    .holdRequest(hold), .dataToHazardUnit(hz), .regWrite(reg_write), .regWriteId(reg_write_id),
    .regWriteData(reg_write_data), .divTimeout(div_timeout)
  );

  forwarding_source #(.DIV_MAX_CYCLES(4)) u_dut_to (
    .clock(clock), .reset(reset), .issueValid(issueValid), .issueRegisterId(issueRegisterId),
    .issueKind(issueKind), .exResult(exResult), .memDataValid(memDataValid),
    .memReadData(memReadData), .divStart(to_div_start), .divDone(divDone), .divResult(divResult),
    .holdRequest(to_hold), .dataToHazardUnit(to_hz), .regWrite(to_reg_write),
    .regWriteId(to_reg_write_id), .regWriteData(to_reg_write_data), .divTimeout(to_div_timeout)
  );

  always #5 clock = ~clock;

  // Count every GPR write and divider start seen on the default-parameter instance.
  always @(negedge clock) begin
    if (reg_write) wr_cnt[reg_write_id] = wr_cnt[reg_write_id] + 1;
    if (div_start) ds_cnt = ds_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [4:0] r, input logic rd, input logic [31:0] d);
    return 64'({r, rd, d});
  endfunction

  function automatic logic [63:0] part(input logic [4:0] r, input logic rd);
    return 64'({r, rd});
  endfunction

  function automatic logic [63:0] wr(input logic w, input logic [4:0] r, input logic [31:0] d);
    return 64'({w, r, d});
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input logic v, input logic [4:0] r, input logic [1:0] k);
    issueValid      = v;
    issueRegisterId = r;
    issueKind       = k;
  endtask

  task automatic check_reset_state(input string who, input logic h, input logic ds,
                                   input logic rw, input logic [4:0] id, input logic [31:0] d,
                                   input logic to, input stage_register_data_t [2:0] e);
    check_eq({who, "_hold"}, 64'(h), 64'(0));
    check_eq({who, "_divstart"}, 64'(ds), 64'(0));
    check_eq({who, "_regwrite"}, wr(rw, id, d), wr(1'b0, 5'd0, 32'd0));
    check_eq({who, "_timeout"}, 64'(to), 64'(0));
    for (int i = 0; i < 3; i++) check_eq({who, "_entry"}, 64'(e[i]), ent(5'd0, 1'b1, 32'd0));
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1;
    issue(1'b0, 5'd0, KIND_NONE);
    exResult = '0; memDataValid = 1'b0; memReadData = '0; divDone = 1'b0; divResult = '0;
    next_cycle(); next_cycle();
    reset = 1'b0; #1;
    check_reset_state("rst", hold, div_start, reg_write, reg_write_id, reg_write_data,
                      div_timeout, hz);

    // Back-to-back ALU
    next_cycle(); issue(1'b1, 5'd5, KIND_ALU);
    next_cycle(); issue(1'b1, 5'd6, KIND_ALU); exResult = 32'h11; #1;
    check_eq("alu_e0_r5", 64'(hz[0]), ent(5'd5, 1'b1, 32'h11));
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); exResult = 32'h22; #1;
    check_eq("alu_e1_r5", 64'(hz[1]), ent(5'd5, 1'b1, 32'h11));
    check_eq("alu_e0_r6", 64'(hz[0]), ent(5'd6, 1'b1, 32'h22));
    next_cycle(); exResult = 32'h0; #1;
    check_eq("alu_wr_r5", wr(reg_write, reg_write_id, reg_write_data), wr(1'b1, 5'd5, 32'h11));
    check_eq("alu_e0_bubble", 64'(hz[0]), ent(5'd0, 1'b1, 32'd0));
    next_cycle(); #1;
    check_eq("alu_wr_r6", wr(reg_write, reg_write_id, reg_write_data), wr(1'b1, 5'd6, 32'h22));
    next_cycle();

    // LOAD with memory wait
    issue(1'b1, 5'd7, KIND_LOAD);
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); #1;
    check_eq("ld_ex_hold", 64'(hold), 64'(0));
    check_eq("ld_e0", part(hz[0].registerId, hz[0].ready), part(5'd7, 1'b0));
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      check_eq("ld_wait_hold", 64'(hold), 64'(1));
      check_eq("ld_wait_e1", part(hz[1].registerId, hz[1].ready), part(5'd7, 1'b0));
    end
    next_cycle(); memDataValid = 1'b1; memReadData = 32'hABCD; #1;
    check_eq("ld_cap_hold", 64'(hold), 64'(1));
    check_eq("ld_cap_e1", part(hz[1].registerId, hz[1].ready), part(5'd7, 1'b0));
    next_cycle(); memDataValid = 1'b0; memReadData = '0; #1;
    check_eq("ld_rel_hold", 64'(hold), 64'(0));
    check_eq("ld_rel_e1", 64'(hz[1]), ent(5'd7, 1'b1, 32'hABCD));
    next_cycle(); #1;
    check_eq("ld_wr_r7", wr(reg_write, reg_write_id, reg_write_data), wr(1'b1, 5'd7, 32'hABCD));
    next_cycle(); #1;
    check_eq("wrcnt_r5", 64'(wr_cnt[5]), 64'(1));
    check_eq("wrcnt_r6", 64'(wr_cnt[6]), 64'(1));
    check_eq("wrcnt_r7", 64'(wr_cnt[7]), 64'(1));

    // DIV; the divDone in the start cycle must be ignored
    next_cycle(); issue(1'b1, 5'd3, KIND_DIV);
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); divDone = 1'b1; divResult = 32'h55; #1;
    check_eq("div_start", 64'(div_start), 64'(1));
    check_eq("div_hold", 64'(hold), 64'(1));
    check_eq("div_e0_start", part(hz[0].registerId, hz[0].ready), part(5'd3, 1'b0));
    next_cycle(); divDone = 1'b0; #1;
    check_eq("div_start_once", 64'(div_start), 64'(0));
    check_eq("div_e0_ignored", part(hz[0].registerId, hz[0].ready), part(5'd3, 1'b0));
    next_cycle(); next_cycle(); #1;
    check_eq("div_e0_wait", part(hz[0].registerId, hz[0].ready), part(5'd3, 1'b0));
    next_cycle(); divDone = 1'b1; divResult = 32'd9; #1;
    check_eq("div_done_hold", 64'(hold), 64'(1));
    check_eq("div_done_e0", part(hz[0].registerId, hz[0].ready), part(5'd3, 1'b0));
    next_cycle(); divDone = 1'b0; divResult = '0; #1;
    check_eq("div_e0_ready", 64'(hz[0]), ent(5'd3, 1'b1, 32'd9));
    check_eq("div_rel_hold", 64'(hold), 64'(0));
    next_cycle(); #1;
    check_eq("div_e1", 64'(hz[1]), ent(5'd3, 1'b1, 32'd9));
    next_cycle(); #1;
    check_eq("div_wr_r3", wr(reg_write, reg_write_id, reg_write_data), wr(1'b1, 5'd3, 32'd9));
    check_eq("div_start_cnt", 64'(ds_cnt), 64'(1));

    // DIV in EX and LOAD in MEM waiting together
    next_cycle(); issue(1'b1, 5'd9, KIND_LOAD);
    next_cycle(); issue(1'b1, 5'd10, KIND_DIV);
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); #1;
    check_eq("sim_hold", 64'(hold), 64'(1));
    check_eq("sim_e0", part(hz[0].registerId, hz[0].ready), part(5'd10, 1'b0));
    check_eq("sim_e1", part(hz[1].registerId, hz[1].ready), part(5'd9, 1'b0));
    next_cycle();
    next_cycle(); divDone = 1'b1; divResult = 32'h1234; #1;
    check_eq("sim_done_hold", 64'(hold), 64'(1));
    next_cycle(); divDone = 1'b0; divResult = '0; #1;
    check_eq("sim_e0_ready", 64'(hz[0]), ent(5'd10, 1'b1, 32'h1234));
    check_eq("sim_e1_wait", part(hz[1].registerId, hz[1].ready), part(5'd9, 1'b0));
    check_eq("sim_ld_hold", 64'(hold), 64'(1));
    next_cycle(); memDataValid = 1'b1; memReadData = 32'h5678; #1;
    check_eq("sim_cap_hold", 64'(hold), 64'(1));
    check_eq("sim_cap_e0", 64'(hz[0]), ent(5'd10, 1'b1, 32'h1234));
    next_cycle(); memDataValid = 1'b0; memReadData = '0; #1;
    check_eq("sim_rel_hold", 64'(hold), 64'(0));
    check_eq("sim_rel_e0", 64'(hz[0]), ent(5'd10, 1'b1, 32'h1234));
    check_eq("sim_rel_e1", 64'(hz[1]), ent(5'd9, 1'b1, 32'h5678));
    next_cycle(); #1;
    check_eq("sim_wr_r9", wr(reg_write, reg_write_id, reg_write_data), wr(1'b1, 5'd9, 32'h5678));
    check_eq("sim_e1_r10", 64'(hz[1]), ent(5'd10, 1'b1, 32'h1234));
    next_cycle(); #1;
    check_eq("sim_wr_r10", wr(reg_write, reg_write_id, reg_write_data), wr(1'b1, 5'd10, 32'h1234));
    next_cycle(); #1;
    check_eq("wrcnt_r9", 64'(wr_cnt[9]), 64'(1));
    check_eq("wrcnt_r10", 64'(wr_cnt[10]), 64'(1));
    check_eq("wrcnt_r3", 64'(wr_cnt[3]), 64'(1));
    check_eq("div_start_cnt2", 64'(ds_cnt), 64'(2));

    // Divider timeout on the DIV_MAX_CYCLES=4 instance
    reset = 1'b1;
    next_cycle(); reset = 1'b0; issue(1'b1, 5'd3, KIND_DIV);
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); #1;
    check_eq("to_start", 64'(to_div_start), 64'(1));
    check_eq("to_flag_early", 64'(to_div_timeout), 64'(0));
    next_cycle(); next_cycle(); next_cycle(); #1;
    check_eq("to_flag_c3", 64'(to_div_timeout), 64'(0));
    check_eq("to_hold_c3", 64'(to_hold), 64'(1));
    next_cycle(); #1;
    check_eq("to_flag", 64'(to_div_timeout), 64'(1));
    check_eq("to_e0", 64'(to_hz[0]), ent(5'd3, 1'b1, 32'd0));
    check_eq("to_hold_rel", 64'(to_hold), 64'(0));
    next_cycle(); next_cycle(); #1;
    check_eq("to_wr_r3", wr(to_reg_write, to_reg_write_id, to_reg_write_data),
             wr(1'b1, 5'd3, 32'd0));
    check_eq("to_flag_sticky", 64'(to_div_timeout), 64'(1));
    check_eq("def_no_timeout", 64'(div_timeout), 64'(0));
    check_eq("def_still_hold", 64'(hold), 64'(1));

    // Register ZERO, NONE, bubble, then reset mid DIV wait
    reset = 1'b1;
    next_cycle(); reset = 1'b0; issue(1'b1, 5'd0, KIND_ALU); exResult = 32'h77;
    next_cycle(); issue(1'b1, 5'd4, KIND_NONE); #1;
    check_eq("z_e0_r0", 64'(hz[0]), ent(5'd0, 1'b1, 32'd0));
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); #1;
    check_eq("z_e0_none", 64'(hz[0]), ent(5'd0, 1'b1, 32'd0));
    check_eq("z_e1_r0", 64'(hz[1]), ent(5'd0, 1'b1, 32'd0));
    next_cycle(); issue(1'b1, 5'd12, KIND_DIV); #1;
    for (int i = 0; i < 3; i++) check_eq("z_entry", 64'(hz[i]), ent(5'd0, 1'b1, 32'd0));
    check_eq("z_no_write_r0", 64'(reg_write), 64'(0));
    next_cycle(); issue(1'b0, 5'd0, KIND_NONE); exResult = '0; #1;
    check_eq("z_e0_div", part(hz[0].registerId, hz[0].ready), part(5'd12, 1'b0));
    check_eq("z_e2_none", 64'(hz[2]), ent(5'd0, 1'b1, 32'd0));
    check_eq("z_no_write_none", 64'(reg_write), 64'(0));
    next_cycle(); reset = 1'b1; #1;
    check_eq("z_hold_pre_rst", 64'(hold), 64'(1));
    next_cycle(); reset = 1'b0; #1;
    check_reset_state("rst2", hold, div_start, reg_write, reg_write_id, reg_write_data,
                      div_timeout, hz);
    check_reset_state("rst2_to", to_hold, to_div_start, to_reg_write, to_reg_write_id,
                      to_reg_write_data, to_div_timeout, to_hz);
    next_cycle(); #1;
    check_eq("wrcnt_r0", 64'(wr_cnt[0]), 64'(0));
    check_eq("wrcnt_r4", 64'(wr_cnt[4]), 64'(0));
    check_eq("wrcnt_r12", 64'(wr_cnt[12]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
